// File: rtl/wb_gpio_bank.sv
// Wishbone-slave GPIO bank: output data/enable, synchronised input readback,
// per-pad edge detection with sticky W1C status and a single level interrupt.
module wb_gpio_bank #(
  parameter int unsigned N_PADS    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [N_PADS-1:0] io_in,
  output logic [N_PADS-1:0] io_out,
  output logic [N_PADS-1:0] io_oeb,
  output logic              irq
);

  localparam logic [5:0] REG_OUT     = 6'h00;
  localparam logic [5:0] REG_OEB     = 6'h01;
  localparam logic [5:0] REG_IN      = 6'h02;
  localparam logic [5:0] REG_RISE_EN = 6'h03;
  localparam logic [5:0] REG_FALL_EN = 6'h04;
  localparam logic [5:0] REG_STATUS  = 6'h05;
  localparam logic [5:0] REG_OUT_SET = 6'h06;
  localparam logic [5:0] REG_OUT_CLR = 6'h07;

  logic              hit, access, wr_en;
  logic [5:0]        reg_sel;
  logic [31:0]       byte_mask, rd_data, dat_q;
  logic [N_PADS-1:0] wr_mask, wr_data, status_clr, edge_set;
  logic [N_PADS-1:0] out_q, oeb_q, rise_en_q, fall_en_q, status_q;
  logic [N_PADS-1:0] sync1_q, sync2_q, prev_q;
  logic              ack_q, irq_q;

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // ack_q gates the second cycle so a held strobe completes every other clock
  assign access  = hit & ~ack_q;
  assign wr_en   = access & wbs_we_i;
  assign reg_sel = wbs_adr_i[7:2];

  assign byte_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wr_mask   = byte_mask[N_PADS-1:0];
  assign wr_data   = wbs_dat_i[N_PADS-1:0] & wr_mask;

  assign status_clr = (wr_en && reg_sel == REG_STATUS) ? wr_data : '0;
  assign edge_set   = (sync2_q & ~prev_q & rise_en_q) | (~sync2_q & prev_q & fall_en_q);

  // Bits above N_PADS and the byte offset within a word carry no information.
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, byte_mask};

  // NOTE: always_comb with a default first on every path keeps the read mux latch-free.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_OUT:     rd_data[N_PADS-1:0] = out_q;
      REG_OEB:     rd_data[N_PADS-1:0] = oeb_q;
      REG_IN:      rd_data[N_PADS-1:0] = sync2_q;
      REG_RISE_EN: rd_data[N_PADS-1:0] = rise_en_q;
      REG_FALL_EN: rd_data[N_PADS-1:0] = fall_en_q;
      REG_STATUS:  rd_data[N_PADS-1:0] = status_q;
      default:     rd_data = '0;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      irq_q     <= 1'b0;
      out_q     <= '0;
      oeb_q     <= '1;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
    end else begin
      ack_q   <= access;
      dat_q   <= (access && !wbs_we_i) ? rd_data : '0;
      irq_q   <= |status_q;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // An edge in the same cycle as a clear wins, so no event is lost.
      status_q <= (status_q & ~status_clr) | edge_set;
      if (wr_en) begin
        case (reg_sel)
          REG_OUT:     out_q     <= (out_q & ~wr_mask) | wr_data;
          REG_OEB:     oeb_q     <= (oeb_q & ~wr_mask) | wr_data;
          REG_RISE_EN: rise_en_q <= (rise_en_q & ~wr_mask) | wr_data;
          REG_FALL_EN: fall_en_q <= (fall_en_q & ~wr_mask) | wr_data;
          REG_OUT_SET: out_q     <= out_q | wr_data;
          REG_OUT_CLR: out_q     <= out_q & ~wr_data;
          default: ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Bench for wb_gpio_bank: a 16-pad instance checked every cycle against a
// register-level model, plus an 8-pad instance sharing the bus at another base.
module tb_wb_gpio_bank;

  localparam logic [31:0] BASE16 = 32'h3000_0000;
  localparam logic [31:0] BASE8  = 32'h3000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;

  logic        ack16, irq16, ack8, irq8;
  logic [31:0] dat16, dat8;
  logic [15:0] io_in16 = '0, io_out16, io_oeb16;
  logic [7:0]  io_in8 = '0, io_out8, io_oeb8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_gpio_bank #(.N_PADS(16), .BASE_ADDR(BASE16)) dut16 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack16), .wbs_dat_o(dat16), .io_in(io_in16), .io_out(io_out16),
    .io_oeb(io_oeb16), .irq(irq16)
  );

  wb_gpio_bank #(.N_PADS(8), .BASE_ADDR(BASE8)) dut8 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack8), .wbs_dat_o(dat8), .io_in(io_in8), .io_out(io_out8),
    .io_oeb(io_oeb8), .irq(irq8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 16-pad instance ----------------
  logic [15:0] m_out, m_oeb, m_rise, m_fall, m_status;
  logic [15:0] h_last, h_prev2, h_prev3;   // io_in sampled 1, 2 and 3 edges ago
  logic        m_ack, m_irq;
  logic [31:0] m_dat;

  task automatic model_reset();
    m_out = '0; m_oeb = 16'hFFFF; m_rise = '0; m_fall = '0; m_status = '0;
    h_last = '0; h_prev2 = '0; h_prev3 = '0;
    m_ack = 1'b0; m_irq = 1'b0; m_dat = '0;
  endtask

  task automatic model_step();
    logic        go;
    logic [15:0] msk, d, evt;
    logic [31:0] rd;
    go  = cyc && stb && (adr[31:8] == BASE16[31:8]) && !m_ack;
    msk = {{8{sel[1]}}, {8{sel[0]}}};
    d   = dat[15:0] & msk;
    // The input seen by software lags the pad by two edges; an edge is a
    // difference between the two-edge-old and three-edge-old samples.
    evt = (h_prev2 & ~h_prev3 & m_rise) | (~h_prev2 & h_prev3 & m_fall);
    case (adr[7:0] & 8'hFC)
      8'h00:   rd = {16'h0, m_out};
      8'h04:   rd = {16'h0, m_oeb};
      8'h08:   rd = {16'h0, h_prev2};
      8'h0C:   rd = {16'h0, m_rise};
      8'h10:   rd = {16'h0, m_fall};
      8'h14:   rd = {16'h0, m_status};
      default: rd = 32'h0;
    endcase
    m_irq = (m_status != 0);
    m_dat = (go && !we) ? rd : 32'h0;
    if (go && we) begin
      case (adr[7:0] & 8'hFC)
        8'h00: m_out  = (m_out  & ~msk) | d;
        8'h04: m_oeb  = (m_oeb  & ~msk) | d;
        8'h0C: m_rise = (m_rise & ~msk) | d;
        8'h10: m_fall = (m_fall & ~msk) | d;
        8'h14: m_status = m_status & ~d;
        8'h18: m_out  = m_out | d;
        8'h1C: m_out  = m_out & ~d;
        default: ;
      endcase
    end
    m_status = m_status | evt;
    m_ack    = go;
    h_prev3 = h_prev2; h_prev2 = h_last; h_last = io_in16;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Compare every cycle, on the falling edge, away from DUT updates.
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_io_out", {16'h0, io_out16}, {16'h0, m_out});
      check("cyc_io_oeb", {16'h0, io_oeb16}, {16'h0, m_oeb});
      check("cyc_irq",    {31'h0, irq16},    {31'h0, m_irq});
      check("cyc_ack",    {31'h0, ack16},    {31'h0, m_ack});
      check("cyc_dat",    dat16,             m_dat);
    end
  end

  // ---------------- bus helpers (called at a falling edge) ----------------
  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdata);
    logic got;
    got = 1'b0; rdata = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if ((a[31:8] == BASE8[31:8]) ? ack8 : ack16) begin
        got   = 1'b1;
        rdata = (a[31:8] == BASE8[31:8]) ? dat8 : dat16;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) check("ack_timeout", {31'h0, got}, 32'h1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    wb_xfer(a, 1'b1, d, s, unused_rd);
  endtask

  task automatic wb_read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(a, 1'b0, 32'h0, 4'hF, r);
    check(name, r, exp);
  endtask

  initial begin
    int acks;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_io_oeb", {16'h0, io_oeb16}, 32'h0000_FFFF);
    check("rst_irq", {31'h0, irq16}, 32'h0);
    wb_read_check("rst_out",     BASE16 + 32'h00, 32'h0);
    wb_read_check("rst_oeb",     BASE16 + 32'h04, 32'h0000_FFFF);
    wb_read_check("rst_rise_en", BASE16 + 32'h0C, 32'h0);
    wb_read_check("rst_fall_en", BASE16 + 32'h10, 32'h0);
    wb_read_check("rst_status",  BASE16 + 32'h14, 32'h0);

    // Held strobe: ack every other cycle
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE16; sel = 4'hF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack16) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held_stb_acks", acks, 2);
    @(negedge clk);

    // Byte enables and set/clear
    wb_write(BASE16 + 32'h00, 32'h0000_A5A5, 4'b0001);
    wb_read_check("out_sel0", BASE16 + 32'h00, 32'h0000_00A5);
    wb_write(BASE16 + 32'h18, 32'h0000_0100, 4'hF);
    wb_read_check("out_set", BASE16 + 32'h00, 32'h0000_01A5);
    wb_write(BASE16 + 32'h1C, 32'h0000_0005, 4'hF);
    check("io_out_clr", {16'h0, io_out16}, 32'h0000_01A0);
    wb_read_check("out_clr", BASE16 + 32'h00, 32'h0000_01A0);
    wb_read_check("out_set_reads0", BASE16 + 32'h18, 32'h0);

    // Rising edge on pad 0
    wb_write(BASE16 + 32'h0C, 32'h0000_0001, 4'hF);
    io_in16[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("rise_irq_early", {31'h0, irq16}, 32'h0);
    @(negedge clk);
    check("rise_irq", {31'h0, irq16}, 32'h1);
    wb_read_check("rise_status", BASE16 + 32'h14, 32'h0000_0001);
    wb_write(BASE16 + 32'h14, 32'h0000_0001, 4'hF);
    wb_read_check("w1c_status", BASE16 + 32'h14, 32'h0);
    check("w1c_irq", {31'h0, irq16}, 32'h0);

    // Falling edge on pad 15 coinciding with its W1C: set wins
    wb_write(BASE16 + 32'h10, 32'h0000_8000, 4'hF);
    io_in16[15] = 1'b1;
    repeat (5) @(negedge clk);
    io_in16[15] = 1'b0;
    repeat (2) @(negedge clk);
    wb_write(BASE16 + 32'h14, 32'h0000_8000, 4'hF);
    @(negedge clk);
    check("simul_irq", {31'h0, irq16}, 32'h1);
    wb_read_check("simul_status", BASE16 + 32'h14, 32'h0000_8000);
    wb_write(BASE16 + 32'h14, 32'h0000_8000, 4'b0001);
    wb_read_check("w1c_lane_off", BASE16 + 32'h14, 32'h0000_8000);
    wb_write(BASE16 + 32'h14, 32'h0000_8000, 4'b0010);
    wb_read_check("w1c_lane_on", BASE16 + 32'h14, 32'h0);
    wb_read_check("in_readback", BASE16 + 32'h08, 32'h0000_0001);

    // Decode: miss never acked, unmapped offset acked with zero
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack16 || ack8) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("miss_no_ack", acks, 0);
    wb_read_check("unmapped_0x40", BASE16 + 32'h40, 32'h0);

    // 8-pad instance: upper bits read zero
    wb_write(BASE8 + 32'h00, 32'hFFFF_FFFF, 4'hF);
    wb_read_check("n8_out", BASE8 + 32'h00, 32'h0000_00FF);
    check("n8_io_out", {24'h0, io_out8}, 32'h0000_00FF);
    wb_write(BASE8 + 32'h04, 32'h0, 4'hF);
    check("n8_io_oeb_written", {24'h0, io_oeb8}, 32'h0);

    // Reset while an ack is high
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE16; sel = 4'hF;
    @(negedge clk);
    check("pre_rst_ack", {31'h0, ack16}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ack_drop", {31'h0, ack16}, 32'h0);
    check("rst_n8_oeb", {24'h0, io_oeb8}, 32'h0000_00FF);
    check("rst_n16_oeb", {16'h0, io_oeb16}, 32'h0000_FFFF);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
